mp3_trigger_ctrl: RTL and testbench

//  Multi-channel successor to the single-line MP3 trigger driver. Each channel's

---
 rtl/mp3_trigger_ctrl_pkg.sv | 17 +
 rtl/mp3_trigger_ctrl_if.sv | 23 ++
 rtl/mp3_trigger_ctrl_pulse_timer.sv | 26 ++
 rtl/mp3_trigger_ctrl.sv | 134 +++++++++++++
 tb/tb_mp3_trigger_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mp3_trigger_ctrl_pkg.sv
// Shared types and helpers for the MP3 trigger controller.
package mp3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  // Counter width able to hold the larger of the two cycle counts.
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mp3_trigger_ctrl_if.sv
// Request/trigger bundle between SoC control logic and the MP3 trigger controller.
interface mp3_trigger_ctrl_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] trig_n;
  logic              busy;
  logic [NUM_CH-1:0] pending;

  modport master (
    output req,
    input  trig_n,
    input  busy,
    input  pending
  );

  modport slave (
    input  req,
    output trig_n,
    output busy,
    output pending
  );
endinterface

// File: rtl/mp3_trigger_ctrl_pulse_timer.sv
// Loadable down-counter shared by the pulse and gap phases; stops at zero.
module mp3_pulse_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mp3_trigger_ctrl.sv
// Multi-channel MP3 trigger controller: queues request edges and serves them as
// timed active-low pulses, lowest channel first. Optional MP3_REQ_SYNC_EN adds a
// 2-flop synchronizer on req.
module mp3_trigger_ctrl
  import mp3_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int PULSE_CYCLES = 5_000_000,
  parameter int GAP_CYCLES   = 10_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  mp3_trigger_ctrl_if.slave   bus
);

  localparam int CW = clog2_max(PULSE_CYCLES, GAP_CYCLES);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [NUM_CH-1:0] req_s;
  logic [NUM_CH-1:0] req_q;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pend_q, pend_d, pend_clr;
  logic [NUM_CH-1:0] trig_q, trig_d;
  logic [GW-1:0]     enc;
  state_t            state_q, state_d;
  logic              busy_q;
  logic              tmr_load;
  logic [CW-1:0]     tmr_val;
  logic              tmr_zero;

`ifdef MP3_REQ_SYNC_EN
  logic [NUM_CH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.req;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = bus.req;
`endif

  assign rise = req_s & ~req_q;

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    enc = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (pend_q[i-1]) enc = GW'(i - 1);
    end
  end

  always_comb begin
    state_d  = state_q;
    trig_d   = trig_q;
    pend_clr = '0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          pend_clr[enc] = 1'b1;
          trig_d        = '1;
          trig_d[enc]   = 1'b0;
          tmr_load      = 1'b1;
          tmr_val       = PULSE_LD;
          state_d       = PULSE;
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          trig_d = '1;
          if (GAP_CYCLES > 0) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
            state_d  = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        trig_d = '1;
        if (tmr_zero) state_d = IDLE;
      end
      default: begin
        trig_d  = '1;
        state_d = IDLE;
      end
    endcase
  end

  // A new edge in the grant cycle re-queues the channel: set has priority.
  assign pend_d = (pend_q & ~pend_clr) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      trig_q  <= '1;
      pend_q  <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      trig_q  <= trig_d;
      pend_q  <= pend_d;
      req_q   <= req_s;
    end
  end

  mp3_pulse_timer #(
    .W(CW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  assign bus.trig_n  = trig_q;
  assign bus.busy    = busy_q;
  assign bus.pending = pend_q;

endmodule

// File: tb/tb_mp3_trigger_ctrl.sv
// Directed bench for mp3_trigger_ctrl (NUM_CH=4, PULSE=4, GAP=3, plus a GAP=0 instance).
module tb_mp3_trigger_ctrl;

`ifdef MP3_REQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mp3_trigger_ctrl_if #(.NUM_CH(4)) bus ();
  mp3_trigger_ctrl_if #(.NUM_CH(4)) bus0 ();

  mp3_trigger_ctrl #(
    .NUM_CH      (4),
    .PULSE_CYCLES(4),
    .GAP_CYCLES  (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  mp3_trigger_ctrl #(
    .NUM_CH      (4),
    .PULSE_CYCLES(4),
    .GAP_CYCLES  (0)
  ) dut_nogap (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] trig_n;
    logic       busy;
    logic [3:0] pending;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] r, input logic [3:0] t, input logic b,
                     input logic [3:0] p, input int reps);
    vec_t v;
    v.req = r; v.trig_n = t; v.busy = b; v.pending = p;
    for (int i = 0; i < reps; i++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs lag the stimulus by LAT cycles; before that the block is idle.
  task automatic run_seg(input int first, input int last, input string name);
    for (int k = first; k <= last + LAT; k++) begin
      int e;
      e = k - LAT;
      bus.req = tbl[(k > last) ? last : k].req;
      @(posedge clk);
      #1;
      if (e >= first) begin
        check({name, ".trig_n"},  bus.trig_n,  tbl[e].trig_n);
        check({name, ".busy"},    bus.busy,    tbl[e].busy);
        check({name, ".pending"}, bus.pending, tbl[e].pending);
      end else begin
        check({name, ".trig_n"},  bus.trig_n,  4'hF);
        check({name, ".busy"},    bus.busy,    1'b0);
        check({name, ".pending"}, bus.pending, 4'h0);
      end
    end
  endtask

  initial begin
    int s2, e2, s3, e3, s4, e4, s5, e5;
    int c0_low, c1_low, c0_rise, c1_fall, both_low;
    logic [3:0] prev;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.req = '0;
    bus0.req = '0;

    // Case 2: single request on channel 2
    s2 = tbl.size();
    add(4'b0100, 4'hF, 1'b0, 4'b0100, 1);
    add(4'b0100, 4'hB, 1'b1, 4'b0000, 4);
    add(4'b0100, 4'hF, 1'b1, 4'b0000, 3);
    add(4'b0100, 4'hF, 1'b0, 4'b0000, 1);
    add(4'b0000, 4'hF, 1'b0, 4'b0000, 1);
    e2 = tbl.size() - 1;

    // Case 3: channels 1 and 3 together
    s3 = tbl.size();
    add(4'b1010, 4'hF, 1'b0, 4'b1010, 1);
    add(4'b1010, 4'hD, 1'b1, 4'b1000, 4);
    add(4'b1010, 4'hF, 1'b1, 4'b1000, 3);
    add(4'b1010, 4'hF, 1'b0, 4'b1000, 1);
    add(4'b1010, 4'h7, 1'b1, 4'b0000, 4);
    add(4'b1010, 4'hF, 1'b1, 4'b0000, 3);
    add(4'b1010, 4'hF, 1'b0, 4'b0000, 1);
    add(4'b0000, 4'hF, 1'b0, 4'b0000, 1);
    e3 = tbl.size() - 1;

    // Case 4: req[0] toggles during its own pulse
    s4 = tbl.size();
    add(4'b0001, 4'hF, 1'b0, 4'b0000 | 4'b0001, 1);
    add(4'b0000, 4'hE, 1'b1, 4'b0000, 1);
    add(4'b0001, 4'hE, 1'b1, 4'b0001, 1);
    add(4'b0000, 4'hE, 1'b1, 4'b0001, 2);
    add(4'b0000, 4'hF, 1'b1, 4'b0001, 3);
    add(4'b0000, 4'hF, 1'b0, 4'b0001, 1);
    add(4'b0000, 4'hE, 1'b1, 4'b0000, 4);
    add(4'b0000, 4'hF, 1'b1, 4'b0000, 3);
    add(4'b0000, 4'hF, 1'b0, 4'b0000, 2);
    e4 = tbl.size() - 1;

    // Case 5: channel 1 edge lands exactly on its grant cycle
    s5 = tbl.size();
    add(4'b0011, 4'hF, 1'b0, 4'b0011, 1);
    add(4'b0010, 4'hE, 1'b1, 4'b0010, 1);
    add(4'b0000, 4'hE, 1'b1, 4'b0010, 3);
    add(4'b0000, 4'hF, 1'b1, 4'b0010, 3);
    add(4'b0000, 4'hF, 1'b0, 4'b0010, 1);
    add(4'b0010, 4'hD, 1'b1, 4'b0010, 4);
    add(4'b0010, 4'hF, 1'b1, 4'b0010, 3);
    add(4'b0010, 4'hF, 1'b0, 4'b0010, 1);
    add(4'b0010, 4'hD, 1'b1, 4'b0000, 4);
    add(4'b0010, 4'hF, 1'b1, 4'b0000, 3);
    add(4'b0010, 4'hF, 1'b0, 4'b0000, 1);
    add(4'b0000, 4'hF, 1'b0, 4'b0000, 1);
    e5 = tbl.size() - 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.trig_n",  bus.trig_n,  4'hF);
    check("rst.busy",    bus.busy,    1'b0);
    check("rst.pending", bus.pending, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Case 1: asynchronous reset in the middle of a channel-0 pulse
    @(negedge clk);
    bus.req = 4'b0001;
    repeat (2 + LAT) @(posedge clk);
    #1;
    check("c1.pulse_low", bus.trig_n, 4'hE);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.req = 4'b0000;
    #1;
    check("c1.rst_trig_n",  bus.trig_n,  4'hF);
    check("c1.rst_busy",    bus.busy,    1'b0);
    check("c1.rst_pending", bus.pending, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("c1.no_pulse", {bus.busy, bus.trig_n}, {1'b0, 4'hF});
    end

    @(negedge clk);
    run_seg(s2, e2, "c2");
    run_seg(s3, e3, "c3");
    run_seg(s4, e4, "c4");
    run_seg(s5, e5, "c5");

    // Case 6: zero-gap instance, back-to-back pulses on channels 0 and 1
    @(negedge clk);
    bus0.req = 4'b0011;
    c0_low = 0; c1_low = 0; c0_rise = -1; c1_fall = -1; both_low = 0;
    prev = bus0.trig_n;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (!bus0.trig_n[0]) c0_low++;
      if (!bus0.trig_n[1]) c1_low++;
      if (!bus0.trig_n[0] && !bus0.trig_n[1]) both_low++;
      if (!prev[0] && bus0.trig_n[0] && c0_rise < 0) c0_rise = cyc;
      if (prev[1] && !bus0.trig_n[1] && c1_fall < 0) c1_fall = cyc;
      prev = bus0.trig_n;
    end
    bus0.req = 4'b0000;
    check("c6.ch0_low_cycles", c0_low, 4);
    check("c6.ch1_low_cycles", c1_low, 4);
    check("c6.overlap",        both_low, 0);
    check("c6.ch1_fall_seen",  (c1_fall >= 0 && c0_rise >= 0), 1'b1);
    check("c6.high_gap",       c1_fall - c0_rise, 1);
    check("c6.idle_busy",      bus0.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
